// File: rtl/sdr_bit_sequencer.sv
// SCL generator and bit-counter sequencer for one SDR transfer of N words.
// Optional SCL low-phase stretching is enabled by defining SDR_SEQ_STRETCH_EN.
module sdr_bit_sequencer #(
    parameter int DIV           = 2,
    parameter int BITS_PER_WORD = 9,
    parameter int CNT_W         = 5
) (
    input  logic             i_sys_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [7:0]       i_num_words,
    input  logic             i_abort,
`ifdef SDR_SEQ_STRETCH_EN
    input  logic             i_stretch,
`endif
    input  logic [CNT_W-1:0] i_cnt_bit_count,
    output logic             o_bitcnt_en,
    output logic             o_scl,
    output logic             o_scl_pos_edge,
    output logic             o_scl_neg_edge,
    output logic             o_busy,
    output logic             o_word_done,
    output logic             o_done,
    output logic             o_aborted,
    output logic [7:0]       o_words_left
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(BITS_PER_WORD - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOW,
        ST_HIGH,
        ST_STOP
    } state_t;

    state_t           state_reg;
    logic [DIV_W-1:0] div_cnt_reg;
    logic             scl_reg;
    logic             bitcnt_en_reg;
    logic             pos_edge_reg;
    logic             neg_edge_reg;
    logic             busy_reg;
    logic             word_done_reg;
    logic             done_reg;
    logic             aborted_reg;
    logic [7:0]       words_left_reg;
    logic             word_end_reg;
    logic             last_word_reg;

    logic div_last;
    logic stretch_hold;
    logic at_word_end;

    assign div_last    = (div_cnt_reg == DIV_LAST);
    assign at_word_end = (i_cnt_bit_count == WORD_LAST);

`ifdef SDR_SEQ_STRETCH_EN
    assign stretch_hold = i_stretch;
`else
    assign stretch_hold = 1'b0;
`endif

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            state_reg      <= ST_IDLE;
            div_cnt_reg    <= '0;
            scl_reg        <= 1'b1;
            bitcnt_en_reg  <= 1'b0;
            pos_edge_reg   <= 1'b0;
            neg_edge_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            word_done_reg  <= 1'b0;
            done_reg       <= 1'b0;
            aborted_reg    <= 1'b0;
            words_left_reg <= 8'd0;
            word_end_reg   <= 1'b0;
            last_word_reg  <= 1'b0;
        end else begin
            pos_edge_reg  <= 1'b0;
            neg_edge_reg  <= 1'b0;
            word_done_reg <= 1'b0;
            done_reg      <= 1'b0;
            aborted_reg   <= 1'b0;

            // The word counter lags the word-end strobe by one cycle.
            if (word_done_reg) begin
                words_left_reg <= words_left_reg - 8'd1;
            end

            if (i_abort && (state_reg != ST_IDLE)) begin
                state_reg      <= ST_IDLE;
                div_cnt_reg    <= '0;
                scl_reg        <= 1'b1;
                bitcnt_en_reg  <= 1'b0;
                busy_reg       <= 1'b0;
                words_left_reg <= 8'd0;
                aborted_reg    <= 1'b1;
                word_end_reg   <= 1'b0;
                last_word_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        scl_reg       <= 1'b1;
                        bitcnt_en_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        div_cnt_reg   <= '0;
                        if (i_start) begin
                            if (i_num_words != 8'd0) begin
                                state_reg      <= ST_SETUP;
                                words_left_reg <= i_num_words;
                                busy_reg       <= 1'b1;
                                bitcnt_en_reg  <= 1'b1;
                            end else begin
                                done_reg <= 1'b1;
                            end
                        end
                    end

                    ST_SETUP: begin
                        if (div_last) begin
                            state_reg    <= ST_LOW;
                            div_cnt_reg  <= '0;
                            scl_reg      <= 1'b0;
                            neg_edge_reg <= 1'b1;
                        end else begin
                            div_cnt_reg <= div_cnt_reg + 1'b1;
                        end
                    end

                    ST_LOW: begin
                        // Restores the enable after a one-cycle word-boundary clear.
                        bitcnt_en_reg <= 1'b1;
                        if (!stretch_hold) begin
                            if (div_last) begin
                                state_reg     <= ST_HIGH;
                                div_cnt_reg   <= '0;
                                scl_reg       <= 1'b1;
                                pos_edge_reg  <= 1'b1;
                                word_done_reg <= at_word_end;
                                word_end_reg  <= at_word_end;
                                last_word_reg <= at_word_end && (words_left_reg == 8'd1);
                            end else begin
                                div_cnt_reg <= div_cnt_reg + 1'b1;
                            end
                        end
                    end

                    ST_HIGH: begin
                        if (div_last) begin
                            div_cnt_reg  <= '0;
                            word_end_reg <= 1'b0;
                            if (last_word_reg) begin
                                state_reg     <= ST_STOP;
                                bitcnt_en_reg <= 1'b0;
                                last_word_reg <= 1'b0;
                            end else begin
                                state_reg     <= ST_LOW;
                                scl_reg       <= 1'b0;
                                neg_edge_reg  <= 1'b1;
                                bitcnt_en_reg <= !word_end_reg;
                            end
                        end else begin
                            div_cnt_reg <= div_cnt_reg + 1'b1;
                        end
                    end

                    ST_STOP: begin
                        if (div_last) begin
                            state_reg   <= ST_IDLE;
                            div_cnt_reg <= '0;
                            done_reg    <= 1'b1;
                            busy_reg    <= 1'b0;
                        end else begin
                            div_cnt_reg <= div_cnt_reg + 1'b1;
                        end
                    end

                    default: begin
                        state_reg     <= ST_IDLE;
                        div_cnt_reg   <= '0;
                        scl_reg       <= 1'b1;
                        bitcnt_en_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_bitcnt_en    = bitcnt_en_reg;
    assign o_scl          = scl_reg;
    assign o_scl_pos_edge = pos_edge_reg;
    assign o_scl_neg_edge = neg_edge_reg;
    assign o_busy         = busy_reg;
    assign o_word_done    = word_done_reg;
    assign o_done         = done_reg;
    assign o_aborted      = aborted_reg;
    assign o_words_left   = words_left_reg;

endmodule

// File: doc/sdr_bit_sequencer.md
# sdr_bit_sequencer

Controller that sequences the SDR bits counter for one transfer of N words. Generates the SCL waveform and its single-cycle edge strobes from the system clock, gates the counter enable, and detects word boundaries from the counter value. Sits between the SDR transfer FSM (start/done handshake) and the bits counter / shift datapath.

## Interface
- DIV, 2: system clocks per SCL half-period; must be ≥ 2. At 50 MHz, DIV=2 gives 12.5 MHz SCL.
- BITS_PER_WORD, 9: bits per word (8 data + T-bit); range 2..31.
- CNT_W, 5: width of the bit count from the counter.

- i_sys_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_start  in  1  transfer request; sampled only in IDLE.
- i_num_words  in  8  word count; sampled together with i_start.
- i_abort  in  1  terminate transfer; ignored in IDLE.
- i_cnt_bit_count  in  CNT_W  current count from the bits counter.
- o_bitcnt_en  out  1  bits counter enable.
- o_scl  out  1  SCL level.
- o_scl_pos_edge  out  1  one-cycle strobe, high in the first cycle o_scl is 1.
- o_scl_neg_edge  out  1  one-cycle strobe, high in the first cycle o_scl is 0.
- o_busy  out  1  transfer in progress.
- o_word_done  out  1  one-cycle pulse at each word end.
- o_done  out  1  one-cycle pulse on normal completion.
- o_aborted  out  1  one-cycle pulse on abort.
- o_words_left  out  8  words remaining, including the current word.

## Operation
- Counter contract:
  - The counter clears synchronously while o_bitcnt_en = 0.
  - While enabled, it increments by 1 in the cycle after each o_scl_pos_edge.
- States: IDLE, SETUP, LOW, HIGH, STOP. All outputs are registered.
- IDLE:
  - o_scl = 1, o_bitcnt_en = 0.
  - i_start = 1 with i_num_words ≠ 0: load o_words_left, enter SETUP, o_busy = 1.
  - i_start = 1 with i_num_words = 0: no SCL activity; o_done pulses the next cycle.
- SETUP:
  - o_scl = 1, o_bitcnt_en = 1, held for DIV cycles.
  - Then enter LOW and strobe o_scl_neg_edge.
- LOW: o_scl = 0 for DIV cycles, then enter HIGH and strobe o_scl_pos_edge.
- HIGH: o_scl = 1 for DIV cycles.
- Word end is the pos edge at which i_cnt_bit_count == BITS_PER_WORD−1. On that edge:
  - o_word_done pulses in the same cycle as the pos-edge strobe.
  - o_words_left decrements the following cycle.
- On leaving HIGH with words remaining:
  - Enter LOW and strobe o_scl_neg_edge.
  - If a word just ended, o_bitcnt_en = 0 for exactly that strobe cycle, clearing the counter.
- On leaving HIGH after the last word:
  - Enter STOP: o_scl = 1, o_bitcnt_en = 0, for DIV cycles.
  - Then pulse o_done, drop o_busy, return to IDLE.
- Abort (any non-IDLE state):
  - Next cycle: IDLE, o_scl = 1, o_bitcnt_en = 0, o_busy = 0, o_words_left = 0, o_aborted = 1 for one cycle.
  - No o_done and no edge strobe.
- i_start while busy is ignored. i_abort and i_start together in IDLE: start is accepted.
- Reset in any state (cycle where i_rst_n = 0 is sampled): next cycle all outputs at reset values, state IDLE.

## Timing
- Reset values:
  - o_scl = 1.
  - o_bitcnt_en, o_scl_pos_edge, o_scl_neg_edge, o_busy, o_word_done, o_done, o_aborted = 0.
  - o_words_left = 0.
- Start sampled at cycle t: o_busy = 1 at t+1; first o_scl_neg_edge at t+1+DIV.
- SCL period is 2·DIV cycles at 50 % duty; strobes never overlap.
- o_done is high at cycle t+1+(2+2·BITS_PER_WORD·N)·DIV.
  - Example: DIV = 2, B = 9, N = 1 gives t+41.
- Zero-word request: o_done at t+1; o_busy stays 0.

## Configuration
- SDR_SEQ_STRETCH_EN defined:
  - Adds input i_stretch (1 bit).
  - While i_stretch = 1 in LOW, the LOW phase is held and o_scl stays 0.
  - The DIV-cycle count resumes where it left off once i_stretch = 0.
  - Stretch is ignored in all other states. Abort still applies during a stretch.
- SDR_SEQ_STRETCH_EN undefined: port absent; LOW is always exactly DIV cycles.

## Test plan
- Reset: hold i_rst_n = 0 for 3 cycles during HIGH of an active transfer → next cycle o_scl = 1, o_busy = 0, o_words_left = 0, all strobes 0.
- Single word (DIV = 2, N = 1):
  - Expect 9 pos strobes, each 4 cycles apart.
  - o_word_done coincides with the pos strobe where the count is 8.
  - o_done at t+41.
- Three words (N = 3):
  - o_bitcnt_en low exactly 2 single cycles, each at a word-boundary neg strobe.
  - Count restarts at 0; o_words_left steps 3 → 2 → 1 → 0.
  - o_done at t+1+(2+54)·2 = t+113.
- Zero words and start while busy:
  - i_num_words = 0 → o_done at t+1, o_scl never toggles.
  - A second i_start mid-transfer → no effect on timing.
- Abort at the 5th bit's LOW phase → o_aborted pulses once, o_scl = 1 and o_bitcnt_en = 0 next cycle, no o_done.
- With SDR_SEQ_STRETCH_EN: hold i_stretch for 7 cycles in LOW of bit 2 → that LOW phase lasts DIV+7 cycles, and o_done is delayed by exactly 7 cycles.
